data_cache: RTL
===============

# data_cache

Direct-mapped, write-back, write-allocate data cache that answers the CPU's D-cache port: `data_read`/`data_write`/`data_mem_address`/`data_mbe`/`data_mem_wdata` in, `data_mem_rdata`/`data_mem_resp` out. It is the responder for the MEM-stage memory requests. Its back side is a line-wide burst port to physical memory (or an arbiter), which it drives as initiator.

## Interface

Reset is synchronous, active-high.

Parameters:
- `S_INDEX`, default 3: index bits; the cache has 2^S_INDEX lines.
- `S_OFFSET`, default 5: byte-offset bits; a line is 2^S_OFFSET bytes (256 bits at the default).

Derived width: tag width = 32 − S_INDEX − S_OFFSET (24 bits at the defaults).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`.
- `mem_address`  in  32  byte address, word-aligned; bits [1:0] are ignored.
- `mem_byte_enable`  in  4  write byte mask.
- `mem_wdata`  in  32  write data, already lane-aligned by the CPU.
- `mem_rdata`  out  32  full word at `mem_address`; valid while `mem_resp`=1.
- `mem_resp`  out  1  one-cycle completion pulse.
- `pmem_read`  out  1  line fill request.
- `pmem_write`  out  1  line writeback request.
- `pmem_address`  out  32  line-aligned address; low S_OFFSET bits are 0.
- `pmem_wdata`  out  2^S_OFFSET×8  writeback line.
- `pmem_rdata`  in  2^S_OFFSET×8  fill line; valid while `pmem_resp`=1.
- `pmem_resp`  in  1  physical memory completion pulse.

## Operation

**Storage, per line:**
- valid bit, dirty bit, tag, data line.
- Only valid and dirty bits are reset. Tags and data are not.

**Address decomposition:**
- tag = `mem_address[31 : S_INDEX+S_OFFSET]`
- index = `mem_address[S_INDEX+S_OFFSET-1 : S_OFFSET]`
- word select = `mem_address[S_OFFSET-1 : 2]`

**Hit:** line valid and its stored tag equals the request tag.

**FSM states:**
- **IDLE**
  - No request: stay.
  - Request and hit, read: register the selected word into `mem_rdata`, go to RESP.
  - Request and hit, write: merge `mem_wdata` into the selected word per byte lane where `mem_byte_enable` is 1; set dirty if `mem_byte_enable` ≠ 0; register the pre-merge word into `mem_rdata`; go to RESP.
  - Miss, line clean or invalid: go to ALLOC.
  - Miss, line valid and dirty: go to WB.
- **RESP**
  - `mem_resp`=1 for exactly this cycle.
  - Request inputs are ignored in this state.
  - Next state: IDLE.
- **WB**
  - `pmem_write`=1.
  - `pmem_address` = {stored tag, index, 0}.
  - `pmem_wdata` = stored line.
  - Hold all three until `pmem_resp`, then go to ALLOC.
- **ALLOC**
  - `pmem_read`=1.
  - `pmem_address` = {request tag, index, 0}.
  - On `pmem_resp`: write `pmem_rdata` into the line, write the tag, set valid=1, dirty=0, go to IDLE. The request re-evaluates in IDLE and now hits.

**Simultaneous `mem_read` and `mem_write`:** treated as a write, per the IDLE write rule.

**Bus exclusivity:** `pmem_read` and `pmem_write` are never both 1.

**Dirty bit:** a fill always clears it. Only a write hit with nonzero mask sets it.

## Timing

**Reset:**
- State goes to IDLE.
- All valid and dirty bits are cleared.
- `mem_resp`, `pmem_read`, `pmem_write` = 0; `mem_rdata` = 0; `pmem_address` = 0.

**Reset mid-operation:** an outstanding WB or ALLOC is abandoned. `pmem_*` requests are 0 in the cycle after the `rst` edge. A late `pmem_resp` arriving in IDLE is ignored.

**Hit latency:** request first seen in IDLE at cycle N → `mem_resp`=1 in cycle N+1. The CPU must drop or change its request in cycle N+2.

**Clean-miss latency:**
- Cycle N: IDLE, miss detected.
- Cycles N+1…: ALLOC, until `pmem_resp` arrives in cycle M.
- Cycle M+1: IDLE, hit.
- Cycle M+2: `mem_resp`=1.

**Dirty miss:** the WB phase precedes ALLOC. `pmem_write` drops in the cycle after its `pmem_resp`, and `pmem_read` rises in that same cycle.

**Output timing:** all outputs are registered or driven purely from the FSM state; there are no combinational paths from the `mem_*` inputs.

**Back-to-back requests:** maximum throughput is one hit every 2 cycles.

## Test plan

- **Reset, then cold read:**
  - Stimulus: read 0x0000_1004.
  - Required: `pmem_read`=1 with `pmem_address`=0x0000_1000. Return a line whose word 1 is 0xDEAD_BEEF. `mem_resp` rises 2 cycles after `pmem_resp`, with `mem_rdata`=0xDEAD_BEEF. `pmem_write` stays 0 throughout.
- **Write hit, byte lane:**
  - Stimulus: after the fill above, write 0x0000_AB00 with mbe=4'b0010 to 0x0000_1004.
  - Required: `mem_resp` in cycle N+1. A following read of 0x0000_1004 returns 0xDEAD_ABEF, with no pmem activity.
- **Dirty eviction:**
  - Stimulus: read 0x0000_2004 (same index, different tag).
  - Required: `pmem_write` with address 0x0000_1000 and a line containing 0xDEAD_ABEF, then `pmem_read` at 0x0000_2000, then `mem_resp`.
- **Clean eviction:**
  - Stimulus: evict the now-clean line at 0x0000_2000 with a read of 0x0000_3000.
  - Required: no `pmem_write`; `pmem_read` only.
- **Reset mid-ALLOC:**
  - Stimulus: assert `rst` while `pmem_read`=1, then pulse `pmem_resp` one cycle later.
  - Required: `pmem_read`=0 after the reset edge; the late `pmem_resp` is ignored. A subsequent read of the same address misses again, since valid was cleared.
- **Read+write together, and mbe=0 write:**
  - Stimulus: `mem_read`=`mem_write`=1 on a hit; separately, a write with mbe=0 on a clean hit line.
  - Required: the combined request behaves as a write and returns the pre-merge word. The mbe=0 write leaves the line clean, so a later eviction issues no `pmem_write`.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage
// and a line-wide physical memory port. All outputs come from registers or FSM state.
module data_cache #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5,
    localparam int LINE_W  = 8 * (2 ** S_OFFSET)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [3:0]        mem_byte_enable,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [1:0]        dbg_state
);
    localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
    localparam int LINES  = 2 ** S_INDEX;
    localparam int WSEL_W = S_OFFSET - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_WB    = 2'd2,
        ST_ALLOC = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag [LINES];
    logic [LINE_W-1:0]  r_data [LINES];
    logic [S_INDEX-1:0] r_idx;
    logic [TAG_W-1:0]   r_req_tag;
    logic [31:0]        r_rdata;
    logic [31:0]        r_pmem_addr;

    logic [TAG_W-1:0]   w_tag;
    logic [S_INDEX-1:0] w_idx;
    logic [WSEL_W-1:0]  w_wsel;
    logic               w_req;
    logic               w_hit;
    logic               w_dirty_victim;
    logic [31:0]        w_word;
    logic               w_fill;
    logic               w_wr_hit;
    logic [1:0]         w_unused_addr;

    assign w_tag          = mem_address[31 -: TAG_W];
    assign w_idx          = mem_address[S_OFFSET +: S_INDEX];
    assign w_wsel         = mem_address[2 +: WSEL_W];
    assign w_unused_addr  = mem_address[1:0];
    assign w_req          = mem_read | mem_write;
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_dirty_victim = r_valid[w_idx] && r_dirty[w_idx];
    assign w_word         = r_data[w_idx][32*int'(w_wsel) +: 32];
    assign w_fill         = (r_state == ST_ALLOC) && pmem_resp && !rst;
    assign w_wr_hit       = (r_state == ST_IDLE) && mem_write && w_hit && !rst;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_hit)               w_next = ST_RESP;
                    else if (w_dirty_victim) w_next = ST_WB;
                    else                     w_next = ST_ALLOC;
                end
            end
            ST_RESP:  w_next = ST_IDLE;
            ST_WB:    if (pmem_resp) w_next = ST_ALLOC;
            ST_ALLOC: if (pmem_resp) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Miss bookkeeping is latched so the pmem side never depends on live CPU inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_dirty     <= '0;
            r_rdata     <= '0;
            r_pmem_addr <= '0;
            r_idx       <= '0;
            r_req_tag   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                if (w_hit) begin
                    r_rdata <= w_word;
                    if (mem_write && (mem_byte_enable != 4'b0000)) r_dirty[w_idx] <= 1'b1;
                end else begin
                    r_idx     <= w_idx;
                    r_req_tag <= w_tag;
                    if (w_dirty_victim) r_pmem_addr <= {r_tag[w_idx], w_idx, {S_OFFSET{1'b0}}};
                    else                r_pmem_addr <= {w_tag, w_idx, {S_OFFSET{1'b0}}};
                end
            end
            if (r_state == ST_WB && pmem_resp) r_pmem_addr <= {r_req_tag, r_idx, {S_OFFSET{1'b0}}};
            if (w_fill) begin
                r_valid[r_idx] <= 1'b1;
                r_dirty[r_idx] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[r_idx] <= pmem_rdata;
            r_tag[r_idx]  <= r_req_tag;
        end
        if (w_wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_enable[b])
                    r_data[w_idx][32*int'(w_wsel) + 8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign mem_rdata    = r_rdata;
    assign mem_resp     = (r_state == ST_RESP);
    assign pmem_read    = (r_state == ST_ALLOC);
    assign pmem_write   = (r_state == ST_WB);
    assign pmem_address = r_pmem_addr;
    assign pmem_wdata   = r_data[r_idx];
    assign dbg_state    = r_state;
endmodule
